vga_scanout: RTL and testbench



---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_timing.sv | 56 +++++
 rtl/vga_scanout.sv | 139 +++++++++++++
 tb/tb_vga_scanout.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, framebuffer geometry,
// the delayed control bundle and RGB332 colour expansion.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FB_W        = 320;
    localparam int FB_H        = 240;
    localparam int SCALE_SHIFT = 1;

    localparam logic [7:0] BORDER = 8'h00;

    // Raster counter width, large enough for both totals
    localparam int CNT_W = 10;

    // Per-pixel control flags carried alongside the framebuffer read
    typedef struct packed {
        logic active;
        logic inimg;
        logic hs;
        logic vs;
        logic frame;
    } ctrl_t;

    // Replicate the high bits of each RGB332 field to fill 8 bits per channel
    function automatic logic [23:0] rgb332_expand(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6],
                p[4:2], p[4:2], p[4:3],
                p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters plus stage-0 decode of active video, sync windows and the
// frame origin. Usable by any block that needs the display raster position.
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [vga_pkg::CNT_W-1:0] h_cnt,
    output logic [vga_pkg::CNT_W-1:0] v_cnt,
    output logic                      active,
    output logic                      hs,
    output logic                      vs,
    output logic                      frame
);
    import vga_pkg::*;

    localparam int LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Horizontal counter wraps each line and steps the vertical counter
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    assign active = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
    assign hs     = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign vs     = (v_cnt >= VS_START) && (v_cnt < VS_END);
    assign frame  = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/vga_scanout.sv
// Display-side framebuffer reader: walks the raster, fetches scaled RGB332
// pixels and drives 8-bit-per-channel VGA outputs two clocks behind the
// raster counters.
module vga_scanout #(
    parameter int         H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int         H_FP        = vga_pkg::H_FP,
    parameter int         H_SYNC      = vga_pkg::H_SYNC,
    parameter int         H_BP        = vga_pkg::H_BP,
    parameter int         V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int         V_FP        = vga_pkg::V_FP,
    parameter int         V_SYNC      = vga_pkg::V_SYNC,
    parameter int         V_BP        = vga_pkg::V_BP,
    parameter int         FB_W        = vga_pkg::FB_W,
    parameter int         FB_H        = vga_pkg::FB_H,
    parameter int         SCALE_SHIFT = vga_pkg::SCALE_SHIFT,
    parameter logic [7:0] BORDER      = vga_pkg::BORDER
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pixel_addr,
    input  logic [7:0]  pixel_val,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        frame_start
);
    import vga_pkg::*;

    localparam int ADDR_W    = $clog2(FB_W * FB_H);
    localparam int LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]  h_cnt;
    logic [CNT_W-1:0]  v_cnt;
    logic              active;
    logic              hs;
    logic              vs;
    logic              frame;
    logic [CNT_W-1:0]  fx;
    logic [CNT_W-1:0]  fy;
    logic [CNT_W-1:0]  v_plus;
    logic [CNT_W-1:0]  fy_next;
    logic              inimg;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] addr_q;
    ctrl_t             ctrl_s0;
    ctrl_t             ctrl_s1;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .h_cnt  (h_cnt),
        .v_cnt  (v_cnt),
        .active (active),
        .hs     (hs),
        .vs     (vs),
        .frame  (frame)
    );

    assign fx      = h_cnt >> SCALE_SHIFT;
    assign fy      = v_cnt >> SCALE_SHIFT;
    assign v_plus  = v_cnt + 1'b1;
    assign fy_next = v_plus >> SCALE_SHIFT;
    assign inimg   = active && (fx < CNT_W'(FB_W)) && (fy < CNT_W'(FB_H));
    assign ctrl_s0 = {active, inimg, hs, vs, frame};

    assign addr_next = row_base + ADDR_W'(fx);

    // Row base holds fy*FB_W for the current line; it steps by FB_W only when the next line maps to a new image row
    always_ff @(posedge clk) begin
        if (reset) begin
            row_base <= '0;
        end else if (h_cnt == H_LAST) begin
            if (v_cnt == V_LAST) begin
                row_base <= '0;
            end else if ((fy_next != fy) && (fy_next < CNT_W'(FB_H))) begin
                row_base <= row_base + ADDR_W'(FB_W);
            end
        end
    end

    // Stage 1: issue the framebuffer read (holding the last address outside the image) and delay the control flags
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            ctrl_s1 <= '0;
        end else begin
            ctrl_s1 <= ctrl_s0;
            if (ctrl_s0.inimg) begin
                addr_q <= addr_next;
            end
        end
    end

    assign pixel_addr = 32'(addr_q);

    // Stage 2: expand the returned pixel (or border colour) and register syncs so every output lines up
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            vga_blank_n <= ctrl_s1.active;
            vga_hsync   <= ~ctrl_s1.hs;
            vga_vsync   <= ~ctrl_s1.vs;
            frame_start <= ctrl_s1.frame;
            if (ctrl_s1.active) begin
                {vga_r, vga_g, vga_b} <= rgb332_expand(ctrl_s1.inimg ? pixel_val : BORDER);
            end else begin
                {vga_r, vga_g, vga_b} <= 24'h0;
            end
        end
    end

    assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: three instances (default timing, narrow framebuffer
// with a coloured border, and a tiny raster that completes whole frames
// quickly) checked every cycle against an arithmetic raster model, plus a
// table of fixed-position vectors and a few multi-cycle sequences.
module tb_vga_scanout;

    typedef struct {
        int         ha, hf, hsw, hb;
        int         va, vf, vsw, vb;
        int         fbw, fbh, sh;
        logic [7:0] border;
    } cfg_t;

    typedef struct {
        string       name;
        int          dut;
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } vec_t;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  key = 8'h00;
    logic        ram_const = 1'b0;
    logic [7:0]  const_val = 8'h00;

    logic [31:0] pa      [NDUT];
    logic [7:0]  pv      [NDUT];
    logic [7:0]  r       [NDUT];
    logic [7:0]  g       [NDUT];
    logic [7:0]  b       [NDUT];
    logic        hsync_n [NDUT];
    logic        vsync_n [NDUT];
    logic        blank_n [NDUT];
    logic        sync_n  [NDUT];
    logic        fs      [NDUT];

    cfg_t        cfg     [NDUT];
    logic [31:0] maddr   [NDUT];
    logic [7:0]  mpv     [NDUT];

    int cyc = 0;
    bit model_on = 1'b0;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Framebuffer model: the registered address is the read request, data is back one clock later
    assign pv[0] = ram_const ? const_val : (pa[0][7:0] ^ key);
    assign pv[1] = ram_const ? const_val : (pa[1][7:0] ^ key);
    assign pv[2] = ram_const ? const_val : (pa[2][7:0] ^ key);

    vga_scanout dut0 (
        .clk(clk), .reset(reset), .pixel_addr(pa[0]), .pixel_val(pv[0]),
        .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]), .vga_hsync(hsync_n[0]),
        .vga_vsync(vsync_n[0]), .vga_blank_n(blank_n[0]), .vga_sync_n(sync_n[0]),
        .frame_start(fs[0])
    );

    vga_scanout #(.FB_W(256), .BORDER(8'h03)) dut1 (
        .clk(clk), .reset(reset), .pixel_addr(pa[1]), .pixel_val(pv[1]),
        .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]), .vga_hsync(hsync_n[1]),
        .vga_vsync(vsync_n[1]), .vga_blank_n(blank_n[1]), .vga_sync_n(sync_n[1]),
        .frame_start(fs[1])
    );

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .FB_W(6), .FB_H(5), .SCALE_SHIFT(1), .BORDER(8'h5A)
    ) dut2 (
        .clk(clk), .reset(reset), .pixel_addr(pa[2]), .pixel_val(pv[2]),
        .vga_r(r[2]), .vga_g(g[2]), .vga_b(b[2]), .vga_hsync(hsync_n[2]),
        .vga_vsync(vsync_n[2]), .vga_blank_n(blank_n[2]), .vga_sync_n(sync_n[2]),
        .frame_start(fs[2])
    );

    // Cycles since the last sampled reset edge: 0 is the cycle the counters sit at the origin
    always @(posedge clk) begin
        if (reset) begin
            cyc      <= 0;
            model_on <= 1'b1;
        end else begin
            cyc <= cyc + 1;
        end
    end

    task automatic finishTest();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
            if (fails >= 40) finishTest();
        end
    endtask

    function automatic logic [23:0] expand(input logic [7:0] p);
        logic [2:0] r3;
        logic [2:0] g3;
        logic [1:0] b2;
        r3 = p[7:5];
        g3 = p[4:2];
        b2 = p[1:0];
        return {r3, r3, r3[2:1], g3, g3, g3[2:1], b2, b2, b2, b2};
    endfunction

    function automatic logic [7:0] ramRead(input logic [31:0] a);
        return ram_const ? const_val : (a[7:0] ^ key);
    endfunction

    function automatic void raster(input cfg_t c, input int n, output int h, output int v);
        int ht;
        int vt;
        ht = c.ha + c.hf + c.hsw + c.hb;
        vt = c.va + c.vf + c.vsw + c.vb;
        h = n % ht;
        v = (n / ht) % vt;
    endfunction

    function automatic bit isActive(input cfg_t c, input int h, input int v);
        return (h < c.ha) && (v < c.va);
    endfunction

    function automatic bit inImage(input cfg_t c, input int h, input int v);
        return isActive(c, h, v) && ((h >> c.sh) < c.fbw) && ((v >> c.sh) < c.fbh);
    endfunction

    // Per-cycle reference: outputs show the raster position two cycles ago, the address the last in-image pixel
    task automatic modelCheck(input int i);
        cfg_t        c;
        int          h, v;
        logic [31:0] new_addr;
        logic [23:0] rgb;
        logic [7:0]  p;
        logic [28:0] exp_o, act_o;
        bit          act_v, hs_v, vs_v;
        c = cfg[i];
        if (cyc == 0) begin
            new_addr = 32'h0;
        end else begin
            raster(c, cyc - 1, h, v);
            if (inImage(c, h, v)) new_addr = 32'((v >> c.sh) * c.fbw + (h >> c.sh));
            else new_addr = maddr[i];
        end
        if (cyc < 2) begin
            exp_o = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        end else begin
            raster(c, cyc - 2, h, v);
            act_v = isActive(c, h, v);
            hs_v = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hsw);
            vs_v = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vsw);
            p = inImage(c, h, v) ? mpv[i] : c.border;
            rgb = act_v ? expand(p) : 24'h0;
            exp_o = {rgb, ~hs_v, ~vs_v, act_v, (h == 0 && v == 0), 1'b0};
        end
        act_o = {r[i], g[i], b[i], hsync_n[i], vsync_n[i], blank_n[i], fs[i], sync_n[i]};
        checkOutput($sformatf("dut%0d_c%0d_video", i, cyc), 64'(act_o), 64'(exp_o));
        checkOutput($sformatf("dut%0d_c%0d_addr", i, cyc), 64'(pa[i]), 64'(new_addr));
        maddr[i] = new_addr;
        mpv[i] = ramRead(new_addr);
    endtask

    // Reference model runs on every sampling edge once the first reset has been seen
    always @(negedge clk) begin
        if (model_on) begin
            for (int i = 0; i < NDUT; i++) modelCheck(i);
        end
    end

    function automatic logic [31:0] getSig(input int d, input int sel);
        case (sel)
            0: return pa[d];
            1: return {8'h0, r[d], g[d], b[d]};
            2: return {31'h0, hsync_n[d]};
            3: return {31'h0, vsync_n[d]};
            4: return {31'h0, blank_n[d]};
            default: return {31'h0, fs[d]};
        endcase
    endfunction

    task automatic applyStimulus(input int rst_cycles, input logic [7:0] k, input bit cm, input logic [7:0] cv);
        @(posedge clk);
        #2;
        reset = 1'b1;
        key = k;
        ram_const = cm;
        const_val = cv;
        repeat (rst_cycles) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic waitCyc(input int target);
        int guard = 0;
        @(negedge clk);
        while (cyc < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) begin
            checks++;
            fails++;
            $display("[TB] FAIL wait_cycle: reached %0d, needed %0d", cyc, target);
        end
    endtask

    // Finds two consecutive starts of the given level and the end of the first run
    task automatic measure(input int d, input int sel, input logic lvl, output int period, output int width);
        int   t_start, t_end, t2;
        int   guard;
        logic prev, cur;
        t_start = -1; t_end = -1; t2 = -1; guard = 0;
        @(negedge clk);
        prev = getSig(d, sel)[0];
        while (t2 < 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
            cur = getSig(d, sel)[0];
            if (cur == lvl && prev != lvl) begin
                if (t_start < 0) t_start = cyc;
                else t2 = cyc;
            end
            if (cur != lvl && prev == lvl && t_start >= 0 && t_end < 0) t_end = cyc;
            prev = cur;
        end
        period = (t2 < 0) ? -1 : t2 - t_start;
        width = (t_end < 0) ? -1 : t_end - t_start;
    endtask

    vec_t tbl [$];
    int   per, wid;

    initial begin
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 320, 240, 1, 8'h00};
        cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 256, 240, 1, 8'h03};
        cfg[2] = '{16, 2, 4, 3, 12, 2, 2, 3, 6, 5, 1, 8'h5A};
        for (int i = 0; i < NDUT; i++) begin
            maddr[i] = 32'h0;
            mpv[i] = 8'h0;
        end

        tbl = '{
            '{"rst_addr",       0, 0,    0, 32'd0},
            '{"rst_hsync",      0, 0,    2, 32'd1},
            '{"rst_blank",      0, 0,    4, 32'd0},
            '{"fs_c1",          0, 1,    5, 32'd0},
            '{"fs_c2",          0, 2,    5, 32'd1},
            '{"fb_fs_c2",       1, 2,    5, 32'd1},
            '{"sm_fs_c2",       2, 2,    5, 32'd1},
            '{"fs_c3",          0, 3,    5, 32'd0},
            '{"sm_vs_351",      2, 351,  3, 32'd1},
            '{"sm_vs_352",      2, 352,  3, 32'd0},
            '{"sm_vs_401",      2, 401,  3, 32'd0},
            '{"sm_vs_402",      2, 402,  3, 32'd1},
            '{"sm_fs_477",      2, 477,  5, 32'd1},
            '{"fb_addr_h511",   1, 512,  0, 32'd255},
            '{"fb_rgb_border",  1, 600,  1, 32'h0000FF},
            '{"fb_addr_hold",   1, 600,  0, 32'd255},
            '{"addr_h638",      0, 639,  0, 32'd319},
            '{"addr_h639",      0, 640,  0, 32'd319},
            '{"blank_h639",     0, 641,  4, 32'd1},
            '{"addr_hold_h640", 0, 641,  0, 32'd319},
            '{"blank_h640",     0, 642,  4, 32'd0},
            '{"rgb_h640",       0, 642,  1, 32'd0},
            '{"hs_657",         0, 657,  2, 32'd1},
            '{"hs_658",         0, 658,  2, 32'd0},
            '{"hs_753",         0, 753,  2, 32'd0},
            '{"hs_754",         0, 754,  2, 32'd1},
            '{"hs_1458",        0, 1458, 2, 32'd0},
            '{"row_base_v2",    0, 1601, 0, 32'd320},
            '{"addr_h3v5",      0, 4004, 0, 32'd641},
            '{"rgb_h3v5",       0, 4005, 1, 32'h920055}
        };

        $display("[TB] fixed-position vectors");
        applyStimulus(2, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < tbl.size(); k++) begin
            if (k == 0 || tbl[k].cyc != tbl[k-1].cyc) waitCyc(tbl[k].cyc);
            checkOutput(tbl[k].name, 64'(getSig(tbl[k].dut, tbl[k].sel)), 64'(tbl[k].exp));
        end

        $display("[TB] sync periods");
        measure(0, 2, 1'b0, per, wid);
        checkOutput("hsync_period", 64'(per), 64'd800);
        checkOutput("hsync_width", 64'(wid), 64'd96);
        measure(2, 5, 1'b1, per, wid);
        checkOutput("sm_frame_period", 64'(per), 64'd475);
        measure(2, 3, 1'b0, per, wid);
        checkOutput("sm_vsync_width", 64'(wid), 64'd50);

        $display("[TB] mid-frame reset");
        applyStimulus(1, 8'h00, 1'b0, 8'h00);
        waitCyc(1900);
        checkOutput("pre_reset_hcnt", 64'(dut0.u_timing.h_cnt), 64'd300);
        checkOutput("pre_reset_vcnt", 64'(dut0.u_timing.v_cnt), 64'd2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_outputs",
                    {r[0], g[0], b[0], hsync_n[0], vsync_n[0], blank_n[0], fs[0], pa[0]},
                    {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0});
        checkOutput("reset_counters", 64'({dut0.u_timing.h_cnt, dut0.u_timing.v_cnt}), 64'd0);
        waitCyc(2);
        checkOutput("fs_after_reset", 64'(fs[0]), 64'd1);

        $display("[TB] constant red pixels");
        applyStimulus(2, 8'h00, 1'b1, 8'hE0);
        waitCyc(10);
        checkOutput("red_active", 64'({r[0], g[0], b[0], blank_n[0]}), 64'({24'hFF0000, 1'b1}));
        waitCyc(307);
        checkOutput("sm_blank_vlow", 64'({r[2], g[2], b[2], blank_n[2]}), 64'd0);
        waitCyc(700);
        checkOutput("red_hblank", 64'({r[0], g[0], b[0], blank_n[0]}), 64'd0);

        $display("[TB] randomized rounds");
        for (int n = 0; n < 6; n++) begin
            applyStimulus($urandom_range(1, 3), 8'($urandom), ($urandom_range(0, 3) == 0),
                          8'($urandom));
            repeat ($urandom_range(300, 3000)) @(posedge clk);
        end

        @(negedge clk);
        finishTest();
    end

endmodule
